// File: rtl/boot_pkg.sv
// boot_pkg: shared definitions for the boot loader.
//   state_t        - loader FSM state encoding
//   BYTES_PER_WORD - stream bytes per instruction word
//   HDR_BYTES      - length-prefix bytes at the start of an image
//   CHK_WIDTH      - width of the running checksum
package boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_WORD   = 3'd3,
        S_FLUSH  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int CHK_WIDTH      = 8;

endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: packs a byte stream into little-endian words.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   clear        - holds the byte index at 0 (used while the loader is idle)
//   byte_valid   - a byte for this word is accepted this cycle
//   byte_data    - the accepted byte
//   last_byte    - the next accepted byte completes a word (index == 3)
//   word_valid   - one-cycle pulse, the cycle after a word completes
//   word_data    - the completed word, valid while word_valid is high
module boot_word_assembler
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  last_byte,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word_data
);

    logic [23:0] low_bytes;
    logic [1:0]  byte_idx;

    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            low_bytes  <= '0;
            byte_idx   <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
            end else if (byte_valid) begin
                if (last_byte) begin
                    // Fourth byte goes straight into the output word, so the
                    // next word may start on the very next cycle.
                    word_data  <= DATA_WIDTH'({byte_data, low_bytes});
                    word_valid <= 1'b1;
                    byte_idx   <= '0;
                end else begin
                    low_bytes[{byte_idx, 3'b000} +: 8] <= byte_data;
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed program image over a byte stream
// and writes it word by word into instruction memory, then raises boot_done
// to hand instruction fetch over from BIOS to instruction memory.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN (8-bit checksum trailer).
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start                - begin a load (only sampled in IDLE)
//   rx_valid/rx_data     - incoming byte stream
//   rx_ready             - a byte transfers when rx_valid && rx_ready
//   imem_we/addr/wdata   - one-cycle word write to instruction memory
//   busy                 - a load is in progress
//   boot_done, boot_err  - terminal status levels, held until rst
//
// Handshake: a byte is consumed on every rising edge where rx_valid and
// rx_ready are both high; rx_ready depends only on the current state, never
// on rx_valid, and stays high for the whole data phase (no mid-word stalls).
module boot_loader
    import boot_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  busy,
    output logic                  boot_done,
    output logic                  boot_err
);

    // Largest word count that fits in instruction memory.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CHK;
`else
    localparam state_t AFTER_DATA = S_DONE;
`endif

    state_t      state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic [15:0] len_full;
    logic        asm_valid;
    logic        last_byte;

    assign len_full = {rx_data, len_lo};

    boot_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == S_IDLE),
        .byte_valid (asm_valid),
        .byte_data  (rx_data),
        .last_byte  (last_byte),
        .word_valid (imem_we),
        .word_data  (imem_wdata)
    );

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [CHK_WIDTH-1:0] sum;
    logic [CHK_WIDTH-1:0] sum_final;
    assign sum_final = sum + rx_data;
`endif

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        asm_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (len_full == 16'd0)
                        state_next = AFTER_DATA;
                    else if ({17'd0, len_full} > MAX_WORDS)
                        state_next = S_ERR;
                    else
                        state_next = S_WORD;
                end
            end
            S_WORD: begin
                rx_ready  = 1'b1;
                asm_valid = rx_valid;
                // word_cnt counts completed words, so the final word is the
                // one completing while word_cnt == N-1.
                if (rx_valid && last_byte && (word_cnt == n_words - 16'd1))
                    state_next = S_FLUSH;
            end
            S_FLUSH: begin
                state_next = AFTER_DATA;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                if (rx_valid)
                    state_next = (sum_final == '0) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: state_next = S_DONE;
            S_ERR:  state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_lo    <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            imem_addr <= BASE_ADDR;
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) begin
                word_cnt  <= '0;
                imem_addr <= BASE_ADDR;
            end
            if (state == S_LEN_LO && rx_valid) len_lo <= rx_data;
            if (state == S_LEN_HI && rx_valid) n_words <= len_full;
            if (asm_valid && last_byte) word_cnt <= word_cnt + 16'd1;
            if (imem_we) imem_addr <= imem_addr + 1'b1;
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Running sum over header and data bytes; the trailer is only compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (state == S_IDLE && start) begin
            sum <= '0;
        end else if (rx_valid && rx_ready && state != S_CHK) begin
            sum <= sum + rx_data;
        end
    end
`endif

    assign busy      = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_WORD)   || (state == S_FLUSH)  ||
                       (state == S_CHK);
    assign boot_done = (state == S_DONE);
    assign boot_err  = (state == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    localparam int         AW   = 4;
    localparam logic [3:0] BASE = 4'd5;

    logic        clk;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        boot_done;
    logic        boot_err;

    boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [35:0] exp_q[$];   // {addr, data} of expected writes
    logic [31:0] img[$];     // words of the image being sent
    logic [7:0]  run_sum;
    logic [35:0] mon_exp;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && imem_we === 1'b1) begin
            check_eq("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check_eq("write", {28'd0, imem_addr, imem_wdata}, {28'd0, mon_exp});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    // All tasks begin and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_outputs",
                 {58'd0, rx_ready, imem_we, busy, boot_done, boot_err, 1'b0},
                 64'd0);
        check_eq("rst_addr", 64'(imem_addr), 64'(BASE));
        check_eq("rst_wdata", 64'(imem_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int   tries;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_eq("rx_ready_gap", 64'(rx_ready), 64'd1);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        run_sum  = run_sum + b;
        tries    = 0;
        ok       = 1'b0;
        while (!ok && tries < 20) begin
            @(negedge clk);
            ok = rx_ready;
            if (tries == 0) check_eq("rx_ready", 64'(ok), 64'd1);
            @(posedge clk); #1;
            tries++;
        end
        if (!ok) check_eq("accept_timeout", 64'(ok), 64'd1);
        rx_valid = 1'b0;
    endtask

    // Header, data words from img (expected writes pushed as they are sent),
    // then the trailer when the checksum build is in use.
    task automatic send_image(input logic [15:0] n, input int gmax, input bit poke_start);
        logic [31:0] w;
        run_sum = 8'h00;
        send_byte(n[7:0], $urandom_range(0, gmax));
        send_byte(n[15:8], $urandom_range(0, gmax));
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            exp_q.push_back({4'(BASE + 4'(i)), w});
            if (poke_start) start = (i == 0);
            for (int b = 0; b < 4; b++)
                send_byte(w[8*b +: 8], $urandom_range(0, gmax));
        end
        start = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - run_sum), $urandom_range(0, gmax));
`endif
    endtask

    // Checks the completion timing after the last byte of an image.
    task automatic finish_check(input bit has_data);
`ifndef BOOT_LOADER_CHECKSUM_EN
        if (has_data) begin
            @(negedge clk);
            check_eq("flush_we", 64'(imem_we), 64'd1);
            check_eq("flush_done", 64'(boot_done), 64'd0);
            check_eq("flush_busy", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
`endif
        @(negedge clk);
        check_eq("done", 64'(boot_done), 64'd1);
        check_eq("done_err", 64'(boot_err), 64'd0);
        check_eq("done_busy", 64'(busy), 64'd0);
        check_eq("done_ready", 64'(rx_ready), 64'd0);
        @(posedge clk); #1;
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- tests ----------------
    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; run_sum = 8'h00;

        // Two words, back-to-back bytes.
        do_reset();
        pulse_start();
        img = '{32'h44332211, 32'h88776655};
        send_image(16'd2, 0, 1'b0);
        finish_check(1'b1);
        // start and rx_valid ignored in DONE
        rx_valid = 1'b1; rx_data = 8'hA5;
        pulse_start();
        @(negedge clk);
        check_eq("done_hold", 64'(boot_done), 64'd1);
        check_eq("done_no_ready", 64'(rx_ready), 64'd0);
        @(posedge clk); #1;
        rx_valid = 1'b0;

        // Same image with random gaps.
        do_reset();
        pulse_start();
        send_image(16'd2, 3, 1'b0);
        finish_check(1'b1);

        // Empty image.
        do_reset();
        pulse_start();
        img = {};
        send_image(16'd0, 0, 1'b0);
        finish_check(1'b0);

        // Over-length image: 17 words into a 16-word memory.
        do_reset();
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check_eq("err", 64'(boot_err), 64'd1);
        check_eq("err_done", 64'(boot_done), 64'd0);
        check_eq("err_ready", 64'(rx_ready), 64'd0);
        check_eq("err_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'h5A;
        pulse_start();
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check_eq("err_hold", 64'(boot_err), 64'd1);
        check_eq("err_hold_ready", 64'(rx_ready), 64'd0);
        @(posedge clk); #1;
        rx_valid = 1'b0;

        // Exactly full memory, random data, start pulsed mid-load.
        do_reset();
        pulse_start();
        img = {};
        for (int i = 0; i < 16; i++) img.push_back($urandom());
        send_image(16'd16, 1, 1'b1);
        finish_check(1'b1);

        // Reset after 3 data bytes, then a fresh load.
        do_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        do_reset();
        pulse_start();
        img = '{32'h44332211};
        send_image(16'd1, 0, 1'b0);
        finish_check(1'b1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Explicit trailers: F5 is good, F4 is bad but the word still lands.
        foreach (img[i]) img.delete(i);
        for (int t = 0; t < 2; t++) begin
            do_reset();
            pulse_start();
            exp_q.push_back({BASE, 32'h04030201});
            send_byte(8'h01, 0); send_byte(8'h00, 0);
            send_byte(8'h01, 0); send_byte(8'h02, 0);
            send_byte(8'h03, 0); send_byte(8'h04, 0);
            send_byte((t == 0) ? 8'hF5 : 8'hF4, 0);
            @(negedge clk);
            check_eq("chk_done", 64'(boot_done), 64'(t == 0));
            check_eq("chk_err", 64'(boot_err), 64'(t == 1));
            @(posedge clk); #1;
            check_eq("chk_queue", 64'(exp_q.size()), 64'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
